multi_line_buffer: RTL and testbench
====================================

Name: multi_line_buffer

Overview:
- RAM-based, runtime-width successor to the shift-register line buffer, used in the image-filter datapath.
- Delays a raster pixel stream by 1..NUM_LINES image lines and presents one vertically aligned column (NUM_LINES+1 taps) per accepted pixel.
- Feeds downstream window/kernel stages (3x3, 5x5).
- Adds frame sync, a runtime line width, fill tracking and an end-of-line marker.

Parameters:
- DATA_WIDTH, 8, bits per pixel.
- MAX_WIDTH, 256, maximum pixels per line; this is the depth of each line memory.
- NUM_LINES, 2, number of delayed lines. Output taps = NUM_LINES+1. Legal range 1..8.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-low.
- enable  in  1  global stall. When low, nothing advances and outputs hold.
- img_width  in  WW=clog2(MAX_WIDTH+1)  pixels per line; sampled only on an accepted sof pixel.
- d_valid  in  1  input pixel valid.
- sof  in  1  first pixel of a frame; qualified by d_valid.
- d  in  DATA_WIDTH  input pixel.
- q  out  (NUM_LINES+1)*DATA_WIDTH  column taps. Slice k is the pixel from k lines earlier; slice 0 is the newest.
- q_valid  out  1  q holds a valid column (one cycle per accepted pixel, once filled).
- q_eol  out  1  q is the last column of a line.
- filled  out  1  NUM_LINES full lines have been stored since the last sof.

Behaviour:
- Accept condition: acc = enable & d_valid. All state changes happen only on acc, except reset.
- Reset (rst low, asynchronous):
  - q=0, q_valid=0, q_eol=0, filled=0.
  - col=0, rows=0, FSM=FILL, latched width wl=MAX_WIDTH.
  - RAM contents are not cleared.
- Width latch on acc&sof: wl <= img_width. An img_width of 0 or above MAX_WIDTH becomes MAX_WIDTH. col restarts at 0, rows<=0, FSM<=FILL. The sof pixel itself is written as column 0.
- Column counter: on acc, col increments and wraps to 0 after wl-1. The wrap event is eol. img_width changes between sof pixels are ignored.
- Line memories: NUM_LINES single-port synchronous RAMs, read-before-write, address=col.
  - On acc, RAM j reads its old word (line j+1 earlier) and writes the tap feeding it.
  - RAM0 is written with d. RAM j is written with RAM j-1's read data from the same cycle (cascade).
- Latency: exactly 1 cycle from acc to outputs. q slice 0 = d; slice k = RAM k-1 read data.
- FSM:
  - FILL: rows counts completed lines (eol events), saturating. Transition to RUN when rows==NUM_LINES at an eol.
  - RUN: stays in RUN until sof or reset.
  - filled = (state==RUN), registered.
- q_valid = registered acc & (RUN, or the transition into RUN is occurring on a pixel other than this one). In other words, the first valid column is column 0 of line NUM_LINES (0-based).
- q_eol = registered (acc & eol). It is asserted together with q when that column is the last one.
- Simultaneous sof and eol: sof wins; col=0.
- enable low while d_valid is high: the pixel is not accepted and q/q_valid/q_eol hold their values.
- Reset mid-frame: the stream is discarded; the next accepted pixel is treated as column 0 of a fresh frame, even without sof.

Optional Feature:
- Macro: MULTI_LINE_BUFFER_BORDER_REPLICATE_EN.
- Defined:
  - q_valid asserts for every acc from the first line.
  - Tap k with k>rows outputs tap rows (top-edge replication); on line 0, all taps equal d.
  - filled still reports the true fill state.
- Undefined: no replication muxes; q_valid is gated by the fill state as described in Behaviour.

Decomposition:
- Package multi_line_buffer_pkg:
  - clog2 constant function.
  - Width constants WW and AW=clog2(MAX_WIDTH).
  - FSM state typedef/localparams FILL=1'b0, RUN=1'b1.
- One sub-module: line_mem. Parametrised DATA_WIDTH/DEPTH, single-port, synchronous read-before-write, with an enable. Instantiated NUM_LINES times in a generate loop.

Test Plan:
- Basic fill (NUM_LINES=2, img_width=4): stream pixels 0..15 with sof on pixel 0, d_valid continuous -> q_valid first high one cycle after pixel 8. q={8'd0,8'd4,8'd8} (slice2,slice1,slice0). q_eol high with pixels 11 and 15. filled rises with pixel 8.
- Stall: same stream with enable low for 3 cycles mid-line -> q/q_valid/q_eol hold; the sequence is identical to the unstalled run.
- Runtime width change: img_width=6 while streaming, with no sof -> wrap stays at 4. Then sof with img_width=6 -> filled=0, eol every 6 pixels, first q_valid on the 13th pixel of the new frame.
- Clamp: sof with img_width=0 and with img_width=300 (MAX_WIDTH=256) -> eol every 256 pixels.
- Async reset mid-line (rst low between clock edges) -> outputs 0 immediately. After release, the stream restarts at col=0 and q_valid stays low for 2 lines.
- Replicate macro defined, img_width=4 -> first pixel d=7 gives q={7,7,7} on the next cycle. Line 1 pixel 4 gives q={0,0,4}.

Source files
------------

// File: rtl/multi_line_buffer_pkg.sv
// multi_line_buffer shared package: width helpers and fill-state encoding.
// Optional feature macro: MULTI_LINE_BUFFER_BORDER_REPLICATE_EN.
package multi_line_buffer_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  localparam int MAX_WIDTH_DEF = 256;
  localparam int WW = clog2(MAX_WIDTH_DEF + 1);
  localparam int AW = clog2(MAX_WIDTH_DEF);

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

endpackage

// File: rtl/multi_line_buffer_line_mem.sv
// Single-port line memory: old word is read out while the new one is written.
// Read data is combinational so a cascade can capture it in the same cycle.
module line_mem
  import multi_line_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 256
) (
  input  logic                       clk,
  input  logic                       en_i,
  input  logic [clog2(DEPTH)-1:0]    addr_i,
  input  logic [DATA_WIDTH-1:0]      wdata_i,
  output logic [DATA_WIDTH-1:0]      rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  assign rdata_o = mem_q[addr_i];

  always_ff @(posedge clk) begin
    if (en_i) mem_q[addr_i] <= wdata_i;
  end

endmodule

// File: rtl/multi_line_buffer.sv
// RAM-based multi-line buffer: emits NUM_LINES+1 aligned taps per pixel.
// Optional feature macro: MULTI_LINE_BUFFER_BORDER_REPLICATE_EN.
module multi_line_buffer
  import multi_line_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_WIDTH  = 256,
  parameter int NUM_LINES  = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                enable,
  input  logic [clog2(MAX_WIDTH+1)-1:0]       img_width,
  input  logic                                d_valid,
  input  logic                                sof,
  input  logic [DATA_WIDTH-1:0]               d,
  output logic [(NUM_LINES+1)*DATA_WIDTH-1:0] q,
  output logic                                q_valid,
  output logic                                q_eol,
  output logic                                filled
);

  localparam int WIDTH_W = clog2(MAX_WIDTH + 1);
  localparam int ADDR_W  = clog2(MAX_WIDTH);
  localparam int ROW_W   = clog2(NUM_LINES + 1);
  localparam int QW      = (NUM_LINES + 1) * DATA_WIDTH;
  localparam logic [WIDTH_W-1:0] MAXW = WIDTH_W'(MAX_WIDTH);
  localparam logic [ROW_W-1:0]   NROW = ROW_W'(NUM_LINES);

  logic                  acc;
  logic                  sof_acc;
  logic                  eol;
  logic [WIDTH_W-1:0]    w_in;
  logic [WIDTH_W-1:0]    wl_eff;
  logic [WIDTH_W-1:0]    wl_q, wl_d;
  logic [ADDR_W-1:0]     col_eff;
  logic [ADDR_W-1:0]     col_q, col_d;
  logic [ROW_W-1:0]      rows_eff;
  logic [ROW_W-1:0]      rows_q, rows_d;
  logic [0:0]            state_eff;
  logic [0:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] tap [NUM_LINES+1];
  logic [DATA_WIDTH-1:0] sel [NUM_LINES+1];
  logic [QW-1:0]         q_q, q_d;
  logic                  vld_q, vld_d;
  logic                  eol_q;

  assign acc     = enable & d_valid;
  assign sof_acc = acc & sof;

  // A sof pixel starts a fresh frame regardless of where the counters sit.
  assign w_in = (img_width == '0 || img_width > MAXW) ?
                MAXW : img_width;
  assign wl_eff    = sof_acc ? w_in : wl_q;
  assign col_eff   = sof_acc ? '0 : col_q;
  assign rows_eff  = sof_acc ? '0 : rows_q;
  assign state_eff = sof_acc ? FILL : state_q;

  assign eol = acc &
    (WIDTH_W'(col_eff) == wl_eff - WIDTH_W'(1));

  always_comb begin
    wl_d    = wl_q;
    col_d   = col_q;
    rows_d  = rows_q;
    state_d = state_q;
    if (acc) begin
      wl_d    = wl_eff;
      col_d   = eol ? '0 : col_eff + ADDR_W'(1);
      rows_d  = rows_eff;
      state_d = state_eff;
      if (eol && rows_eff != NROW) begin
        rows_d = rows_eff + ROW_W'(1);
        if (rows_eff + ROW_W'(1) == NROW) state_d = RUN;
      end
    end
  end

  assign tap[0] = d;

  for (genvar j = 0; j < NUM_LINES; j++) begin : g_line
    line_mem #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (MAX_WIDTH)
    ) u_mem (
      .clk    (clk),
      .en_i   (acc),
      .addr_i (col_eff),
      .wdata_i(tap[j]),
      .rdata_o(tap[j+1])
    );
  end

`ifdef MULTI_LINE_BUFFER_BORDER_REPLICATE_EN
  // Taps above the top image row repeat the oldest real row.
  always_comb begin
    for (int k = 0; k <= NUM_LINES; k++) begin
      sel[k] = tap[k];
      if (ROW_W'(k) > rows_eff) sel[k] = tap[rows_eff];
    end
  end
  assign vld_d = acc;
`else
  assign sel   = tap;
  assign vld_d = acc & (state_eff == RUN);
`endif

  always_comb begin
    q_d = '0;
    for (int k = 0; k <= NUM_LINES; k++) begin
      q_d[k*DATA_WIDTH +: DATA_WIDTH] = sel[k];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wl_q    <= MAXW;
      col_q   <= '0;
      rows_q  <= '0;
      state_q <= FILL;
      q_q     <= '0;
      vld_q   <= 1'b0;
      eol_q   <= 1'b0;
    end else begin
      wl_q    <= wl_d;
      col_q   <= col_d;
      rows_q  <= rows_d;
      state_q <= state_d;
      if (acc) q_q <= q_d;
      if (enable) begin
        vld_q <= vld_d;
        eol_q <= eol;
      end
    end
  end

  assign q       = q_q;
  assign q_valid = vld_q;
  assign q_eol   = eol_q;
  assign filled  = (state_q == RUN);

endmodule

// File: tb/tb_multi_line_buffer.sv
// Directed bench for multi_line_buffer with a frame-history scoreboard.
// Honours MULTI_LINE_BUFFER_BORDER_REPLICATE_EN when defined.
module tb_multi_line_buffer;

  localparam int DW = 8;
  localparam int MW = 256;
  localparam int NL = 2;

  typedef struct {
    logic             v;
    logic             e;
    logic             f;
    logic [(NL+1)*DW-1:0] q;
  } exp_t;

  logic                 clk;
  logic                 rst;
  logic                 enable;
  logic [8:0]           img_width;
  logic                 d_valid;
  logic                 sof;
  logic [DW-1:0]        d;
  logic [(NL+1)*DW-1:0] q;
  logic                 q_valid;
  logic                 q_eol;
  logic                 filled;

  int          total;
  int          bad;
  int          n;
  int          wm;
  logic [DW-1:0] hist [$];
  exp_t        sbq [$];

  multi_line_buffer #(
    .DATA_WIDTH(DW),
    .MAX_WIDTH (MW),
    .NUM_LINES (NL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .img_width(img_width),
    .d_valid  (d_valid),
    .sof      (sof),
    .d        (d),
    .q        (q),
    .q_valid  (q_valid),
    .q_eol    (q_eol),
    .filled   (filled)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    n  = 0;
    wm = MW;
  endtask

  task automatic push_exp(input logic [DW-1:0] px,
                          input logic s,
                          input int w);
    exp_t e;
    int l;
    int c;
    int kk;
    if (s) begin
      hist.delete();
      n  = 0;
      wm = (w == 0 || w > MW) ? MW : w;
    end
    hist.push_back(px);
    l   = n / wm;
    c   = n % wm;
    e.e = (c == wm - 1);
    e.f = (n + 1 >= NL * wm);
`ifdef MULTI_LINE_BUFFER_BORDER_REPLICATE_EN
    e.v = 1'b1;
`else
    e.v = (l >= NL);
`endif
    e.q = '0;
    for (int k = 0; k <= NL; k++) begin
      kk = (k > l) ? l : k;
      e.q[k*DW +: DW] = hist[n - kk * wm];
    end
    n++;
    sbq.push_back(e);
  endtask

  task automatic step(input logic en, input logic dv,
                      input logic s, input logic [DW-1:0] px,
                      input int w);
    exp_t e;
    logic [(NL+1)*DW-1:0] pq;
    logic pv, pe, pf;
    enable    = en;
    d_valid   = dv;
    sof       = s;
    d         = px;
    img_width = 9'(w);
    if (en && dv) push_exp(px, s, w);
    pq = q;
    pv = q_valid;
    pe = q_eol;
    pf = filled;
    @(posedge clk);
    #1;
    if (en && dv) begin
      e = sbq.pop_front();
      check("q_valid", 32'(q_valid), 32'(e.v));
      check("q_eol", 32'(q_eol), 32'(e.e));
      check("filled", 32'(filled), 32'(e.f));
      if (e.v) check("q", 32'(q), 32'(e.q));
    end else if (!en) begin
      check("hold_q", 32'(q), 32'(pq));
      check("hold_valid", 32'(q_valid), 32'(pv));
      check("hold_eol", 32'(q_eol), 32'(pe));
      check("hold_filled", 32'(filled), 32'(pf));
    end else begin
      check("idle_valid", 32'(q_valid), 32'(0));
      check("idle_filled", 32'(filled), 32'(pf));
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b0;
    enable    = 1'b0;
    d_valid   = 1'b0;
    sof       = 1'b0;
    d         = '0;
    img_width = '0;
    model_reset();
    #12;
    check("rst_q", 32'(q), 32'(0));
    check("rst_valid", 32'(q_valid), 32'(0));
    check("rst_eol", 32'(q_eol), 32'(0));
    check("rst_filled", 32'(filled), 32'(0));
    @(negedge clk);
    rst = 1'b1;

    // basic fill, width 4
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b1, i == 0, DW'(i), 4);
`ifdef MULTI_LINE_BUFFER_BORDER_REPLICATE_EN
      if (i == 4) check("repl_l1", 32'(q), 32'h000004);
`endif
      if (i == 8) check("first_col", 32'(q), 32'h000408);
      if (i == 11) check("eol11", 32'(q_eol), 32'(1));
    end

    // same stream with a 3-cycle stall mid-line
    for (int i = 0; i < 16; i++) begin
      if (i == 6) begin
        for (int s = 0; s < 3; s++) step(1'b0, 1'b1, 1'b0, 8'hee, 4);
      end
      step(1'b1, 1'b1, i == 0, DW'(i), 4);
      if (i == 8) check("stall_col", 32'(q), 32'h000408);
    end
    step(1'b1, 1'b0, 1'b0, 8'h00, 4);

    // width change without sof is ignored
    for (int i = 16; i < 26; i++) step(1'b1, 1'b1, 1'b0, DW'(i), 6);
    // new frame at width 6
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, i == 0, DW'($urandom_range(255)), 6);
      if (i == 0) check("sof_unfill", 32'(filled), 32'(0));
    end

    // clamped widths
    for (int i = 0; i < 260; i++)
      step(1'b1, 1'b1, i == 0, DW'($urandom_range(255)), 0);
    for (int i = 0; i < 260; i++)
      step(1'b1, 1'b1, i == 0, DW'($urandom_range(255)), 300);

    // async reset mid-line
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, i == 0, DW'(i + 1), 4);
    #2;
    rst = 1'b0;
    #1;
    check("arst_q", 32'(q), 32'(0));
    check("arst_valid", 32'(q_valid), 32'(0));
    check("arst_filled", 32'(filled), 32'(0));
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 520; i++)
      step(1'b1, 1'b1, 1'b0, DW'($urandom_range(255)), 4);

`ifdef MULTI_LINE_BUFFER_BORDER_REPLICATE_EN
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, i == 0, (i == 0) ? 8'd7 : DW'(i), 4);
      if (i == 0) check("repl_l0", 32'(q), 32'h070707);
      if (i == 4) check("repl_l1b", 32'(q), 32'h070704);
    end
`endif

    check("sb_empty", 32'(sbq.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
